// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream program loader for the rv16 instruction memory.
//            Accepts a little-endian stream (length, N data words, XOR
//            checksum), writes each word through the memory write port and
//            holds the core in reset until a full image has been verified.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous active-high reset
//   i_start     in   1   one-cycle pulse, begins a load (IDLE/DONE/ERROR only)
//   i_in_valid  in   1   host byte valid
//   i_in_data   in   8   host byte
//   o_in_ready  out  1   loader accepts a byte this cycle
//   o_mem_addr  out  16  instruction word address (zero-extended)
//   o_mem_data  out  16  instruction word to write
//   o_mem_we    out  1   one-cycle write strobe
//   o_cpu_rst   out  1   core reset, high while not DONE
//   o_busy      out  1   load in progress
//   o_done      out  1   image loaded and verified
//   o_error     out  1   load aborted (length or checksum)
// ============================================================================
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_data,
  output logic        o_mem_we,
  output logic        o_cpu_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_LO = 4'd1,
    S_LEN_HI = 4'd2,
    S_DAT_LO = 4'd3,
    S_DAT_HI = 4'd4,
    S_WRITE  = 4'd5,
    S_CK_LO  = 4'd6,
    S_CK_HI  = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_in_ready;
  logic          r_mem_we;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_mem_data;
  logic          r_cpu_rst;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  // Counter is one bit wider than the address so N == MAX_WORDS terminates.
  logic [ADDR_W:0] r_cnt;
  logic [15:0]     r_len;
  logic [15:0]     r_csum;
  // Low byte of whichever 16-bit field is currently being assembled.
  logic [7:0]      r_lo;

  logic            w_xfer;
  logic            w_start_ok;
  logic [ADDR_W:0] w_cnt_inc;
  logic [15:0]     w_field;
  logic            w_next_byte_state;

  assign w_xfer     = r_in_ready & i_in_valid;
  assign w_start_ok = i_start & ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERROR));
  assign w_cnt_inc  = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
  assign w_field    = {i_in_data, r_lo};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer) begin
          if ({1'b0, w_field} > c_MAX_WORDS) w_next = S_ERROR;
          else if (w_field == 16'd0)         w_next = S_CK_LO;
          else                               w_next = S_DAT_LO;
        end
      end
      S_DAT_LO: if (w_xfer) w_next = S_DAT_HI;
      S_DAT_HI: if (w_xfer) w_next = S_WRITE;
      S_WRITE: begin
        if (16'(w_cnt_inc) < r_len) w_next = S_DAT_LO;
        else                        w_next = S_CK_LO;
      end
      S_CK_LO:  if (w_xfer) w_next = S_CK_HI;
      S_CK_HI: begin
        if (w_xfer) begin
          // r_csum already includes every word: WRITE precedes CK_LO.
          if (w_field == r_csum) w_next = S_DONE;
          else                   w_next = S_ERROR;
        end
      end
      S_DONE:   if (w_start_ok) w_next = S_LEN_LO;
      S_ERROR:  if (w_start_ok) w_next = S_LEN_LO;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_next_byte_state = (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                             (w_next == S_DAT_LO) || (w_next == S_DAT_HI) ||
                             (w_next == S_CK_LO)  || (w_next == S_CK_HI);

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_in_ready <= w_next_byte_state;
      r_mem_we   <= (w_next == S_WRITE);
      r_cpu_rst  <= (w_next != S_DONE);
      r_busy     <= w_next_byte_state || (w_next == S_WRITE);
      r_done     <= (w_next == S_DONE);
      r_error    <= (w_next == S_ERROR);
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_len      <= 16'd0;
      r_csum     <= 16'd0;
      r_lo       <= 8'd0;
      r_mem_addr <= 16'd0;
      r_mem_data <= 16'd0;
    end else begin
      if (w_start_ok) begin
        r_cnt  <= '0;
        r_len  <= 16'd0;
        r_csum <= 16'd0;
      end
      if (w_xfer && ((r_state == S_LEN_LO) || (r_state == S_DAT_LO) ||
                     (r_state == S_CK_LO))) begin
        r_lo <= i_in_data;
      end
      if (w_xfer && (r_state == S_LEN_HI)) begin
        r_len <= w_field;
      end
      // Address and data are loaded on entry to WRITE and then held.
      if (w_xfer && (r_state == S_DAT_HI)) begin
        r_mem_data <= w_field;
        r_mem_addr <= {{(16-ADDR_W){1'b0}}, r_cnt[ADDR_W-1:0]};
      end
      if (r_state == S_WRITE) begin
        r_csum <= r_csum ^ r_mem_data;
        r_cnt  <= w_cnt_inc;
      end
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_mem_we   = r_mem_we;
  assign o_cpu_rst  = r_cpu_rst;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_error    = r_error;

endmodule
`default_nettype wire
